// File: rtl/pit_data_responder_pkg.sv
// Shared constants and types for the PIT data responder.
// Optional feature macro: PIT_LIFETIME_EN (per-entry lifetime counters).
package pit_data_responder_pkg;

   localparam int PREFIX_W   = 64;
   localparam int LEN_W      = 6;
   localparam int ENTRIES    = 16;
   localparam int FACE_W     = 2;
   localparam int DATA_BYTES = 1024;
   localparam int LIFETIME   = 4096;

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int CNT_W  = $clog2(DATA_BYTES);
   localparam int LIFE_W = $clog2(LIFETIME + 1);

   typedef struct packed {
      logic                valid;
      logic [PREFIX_W-1:0] prefix;
      logic [LEN_W-1:0]    len;
      logic [FACE_W-1:0]   face;
   } pit_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MATCH,
      ST_START,
      ST_RECV
   } pit_state_e;

endpackage

// File: rtl/pit_data_responder_if.sv
// Interest, FIB and face signal bundle of the PIT data responder.
// Optional feature macro: PIT_LIFETIME_EN (no effect on this bundle).
interface pit_data_responder_if;
   import pit_data_responder_pkg::*;

   logic                interest_valid;
   logic [PREFIX_W-1:0] interest_prefix;
   logic [LEN_W-1:0]    interest_len;
   logic [FACE_W-1:0]   interest_face;
   logic                interest_ready;
   logic [PREFIX_W-1:0] fib_prefix;
   logic [LEN_W-1:0]    fib_len;
   logic                fib_prefix_ready;
   logic [7:0]          fib_data;
   logic                rejected;
   logic                start_send_to_pit;
   logic [7:0]          face_data;
   logic                face_data_valid;
   logic                face_last;
   logic [FACE_W-1:0]   face_id;
   logic                busy;

   modport master (
      output interest_valid, interest_prefix,
      output interest_len, interest_face,
      output fib_prefix, fib_len,
      output fib_prefix_ready, fib_data,
      input  interest_ready, rejected,
      input  start_send_to_pit, face_data,
      input  face_data_valid, face_last,
      input  face_id, busy
   );

   modport slave (
      input  interest_valid, interest_prefix,
      input  interest_len, interest_face,
      input  fib_prefix, fib_len,
      input  fib_prefix_ready, fib_data,
      output interest_ready, rejected,
      output start_send_to_pit, face_data,
      output face_data_valid, face_last,
      output face_id, busy
   );

endinterface

// File: rtl/pit_data_responder_match_cam.sv
// Parallel (prefix,len) compare over the PIT with lowest-index priority.
// Optional feature macro: PIT_LIFETIME_EN (no effect on this module).
module pit_match_cam
   import pit_data_responder_pkg::*;
(
   input  pit_entry_t          tbl [ENTRIES],
   input  logic [PREFIX_W-1:0] key_prefix,
   input  logic [LEN_W-1:0]    key_len,
   output logic                hit,
   output logic [IDX_W-1:0]    hit_idx
);

   logic [ENTRIES-1:0] eq;

   // Per-entry exact match: valid, same length, all prefix bits equal
   always_comb begin
      eq = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         eq[i] = tbl[i].valid &&
                 (tbl[i].len == key_len) &&
                 (tbl[i].prefix == key_prefix);
      end
   end

   // Priority encode, lowest index wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (eq[i]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/pit_data_responder.sv
// PIT responder: answers FIB prefix queries and forwards the payload.
// Optional feature macro: PIT_LIFETIME_EN (per-entry expiry counters).
module pit_data_responder
   import pit_data_responder_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   pit_data_responder_if.slave bus
);

   pit_entry_t          tbl [ENTRIES];
   pit_state_e          state_q;
   pit_state_e          state_d;
   logic [PREFIX_W-1:0] q_prefix;
   logic [LEN_W-1:0]    q_len;
   logic [IDX_W-1:0]    cur_idx;
   logic [CNT_W-1:0]    byte_cnt;
   logic                m_hit;
   logic [IDX_W-1:0]    m_idx;
   logic                d_hit;
   logic [IDX_W-1:0]    d_idx;
   logic                full;
   logic [IDX_W-1:0]    free_idx;
   logic                ins_acc;
   logic                last_beat;
   logic                retire;

   pit_match_cam u_match (
      .tbl        (tbl),
      .key_prefix (q_prefix),
      .key_len    (q_len),
      .hit        (m_hit),
      .hit_idx    (m_idx)
   );

   pit_match_cam u_dup (
      .tbl        (tbl),
      .key_prefix (bus.interest_prefix),
      .key_len    (bus.interest_len),
      .hit        (d_hit),
      .hit_idx    (d_idx)
   );

   // Lowest free slot, evaluated on the pre-retire table
   always_comb begin
      full     = 1'b1;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!tbl[i].valid) begin
            full     = 1'b0;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign bus.interest_ready = !full;
   assign ins_acc   = bus.interest_valid && !full;
   assign last_beat = byte_cnt == CNT_W'(DATA_BYTES - 1);
   assign retire    = (state_q == ST_RECV) && last_beat;
   assign bus.busy  = state_q != ST_IDLE;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: query, match, start pulse, payload stream
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.fib_prefix_ready) state_d = ST_MATCH;
         ST_MATCH: state_d = m_hit ? ST_START : ST_IDLE;
         ST_START: state_d = ST_RECV;
         ST_RECV:  if (last_beat) state_d = ST_IDLE;
      endcase
   end

   // Query latch, response pulses and payload forwarding
   always_ff @(posedge clk) begin
      if (rst) begin
         q_prefix              <= '0;
         q_len                 <= '0;
         cur_idx               <= '0;
         byte_cnt              <= '0;
         bus.rejected          <= 1'b0;
         bus.start_send_to_pit <= 1'b0;
         bus.face_data         <= '0;
         bus.face_data_valid   <= 1'b0;
         bus.face_last         <= 1'b0;
         bus.face_id           <= '0;
      end else begin
         bus.rejected          <= (state_q == ST_MATCH) && !m_hit;
         bus.start_send_to_pit <= (state_q == ST_MATCH) && m_hit;
         bus.face_data_valid   <= state_q == ST_RECV;
         bus.face_last         <= retire;
         if (state_q == ST_IDLE && bus.fib_prefix_ready) begin
            q_prefix <= bus.fib_prefix;
            q_len    <= bus.fib_len;
         end
         if (state_q == ST_MATCH && m_hit) begin
            cur_idx     <= m_idx;
            bus.face_id <= tbl[m_idx].face;
            byte_cnt    <= '0;
         end
         if (state_q == ST_RECV) begin
            bus.face_data <= bus.fib_data;
            if (!last_beat) byte_cnt <= byte_cnt + CNT_W'(1);
         end
      end
   end

`ifdef PIT_LIFETIME_EN
   logic [LIFE_W-1:0] life_q [ENTRIES];
   logic              locked;

   assign locked = (state_q == ST_START) || (state_q == ST_RECV);

   // Lifetime down-counters; the entry being served is frozen
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) life_q[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (ins_acc && ((d_hit && d_idx == IDX_W'(i)) ||
                            (!d_hit && free_idx == IDX_W'(i))))
               life_q[i] <= LIFE_W'(LIFETIME);
            else if (tbl[i].valid && life_q[i] != '0 &&
                     !(locked && cur_idx == IDX_W'(i)))
               life_q[i] <= life_q[i] - LIFE_W'(1);
         end
      end
   end
`endif

   // Table: expiry, insert/refresh, then retire (retire wins)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
      end else begin
`ifdef PIT_LIFETIME_EN
         for (int i = 0; i < ENTRIES; i++) begin
            if (tbl[i].valid && life_q[i] == '0 &&
                !(locked && cur_idx == IDX_W'(i)))
               tbl[i].valid <= 1'b0;
         end
`endif
         if (ins_acc) begin
            if (d_hit) begin
               tbl[d_idx].face <= bus.interest_face;
            end else begin
               tbl[free_idx] <= '{valid:  1'b1,
                                  prefix: bus.interest_prefix,
                                  len:    bus.interest_len,
                                  face:   bus.interest_face};
            end
         end
         if (retire) tbl[cur_idx].valid <= 1'b0;
      end
   end

endmodule
